// File: rtl/vec_stream_row_collector.sv
// rtl/vec_stream_row_collector.sv - assembles tile beats into rows in a ping-pong row buffer with a tile read port
module vec_stream_row_collector #(
  parameter int TILE_SIZE  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int D          = 256,
  parameter int N_TILES    = D / TILE_SIZE,
  parameter int TIDX_W     = $clog2(N_TILES),
  parameter int CNT_W      = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]   in_vec,
  output logic                                          row_valid,
  input  logic                                          row_release,
  input  logic                                          rd_en,
  input  logic        [TIDX_W-1:0]                      rd_idx,
  output logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]   rd_vec,
  output logic                                          rd_vec_valid,
  output logic        [TIDX_W-1:0]                      wr_tile_cnt,
  output logic        [CNT_W-1:0]                       rows_done
);

  localparam int TW = TILE_SIZE * DATA_WIDTH;

  logic [TW-1:0] buf_mem [2*N_TILES];

  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [TIDX_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rows_done_q, rows_done_d;
  logic              alive_q, alive_d;
  logic              rd_vec_valid_q, rd_vec_valid_d;
  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0] rd_vec_q, rd_vec_d;

  logic accept;
  logic release_ok;

  // alive_q keeps in_ready low while reset is asserted and until the first clock after it
  assign in_ready     = alive_q && !bank_full_q[wr_bank_q];
  assign row_valid    = bank_full_q[rd_bank_q];
  assign accept       = in_valid && in_ready;
  assign release_ok   = row_release && row_valid;
  assign rd_vec       = rd_vec_q;
  assign rd_vec_valid = rd_vec_valid_q;
  assign wr_tile_cnt  = wr_cnt_q;
  assign rows_done    = rows_done_q;

  always_comb begin
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    bank_full_d    = bank_full_q;
    wr_cnt_d       = wr_cnt_q;
    rows_done_d    = rows_done_q;
    alive_d        = 1'b1;
    rd_vec_valid_d = rd_en && row_valid;
    rd_vec_d       = rd_vec_q;

    if (accept) begin
      if (wr_cnt_q == TIDX_W'(N_TILES - 1)) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
        wr_cnt_d               = '0;
        rows_done_d            = rows_done_q + 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    // the filling bank is never full, so this never collides with the completion above
    if (release_ok) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    if (rd_vec_valid_d) begin
      rd_vec_d = buf_mem[{rd_bank_q, rd_idx}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      bank_full_q    <= '0;
      wr_cnt_q       <= '0;
      rows_done_q    <= '0;
      alive_q        <= 1'b0;
      rd_vec_valid_q <= 1'b0;
      rd_vec_q       <= '0;
    end else begin
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      bank_full_q    <= bank_full_d;
      wr_cnt_q       <= wr_cnt_d;
      rows_done_q    <= rows_done_d;
      alive_q        <= alive_d;
      rd_vec_valid_q <= rd_vec_valid_d;
      rd_vec_q       <= rd_vec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_mem[{wr_bank_q, wr_cnt_q}] <= in_vec;
    end
  end

endmodule

// File: tb/tb_vec_stream_row_collector.sv
// tb/tb_vec_stream_row_collector.sv - scoreboard bench for vec_stream_row_collector
module tb_vec_stream_row_collector;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [3:0][15:0]  in_vec = '0;
  logic                     row_valid;
  logic                     row_release = 1'b0;
  logic                     rd_en = 1'b0;
  logic        [5:0]        rd_idx = '0;
  logic signed [3:0][15:0]  rd_vec;
  logic                     rd_vec_valid;
  logic        [5:0]        wr_tile_cnt;
  logic        [15:0]       rows_done;

  int n_tests = 0;
  int n_fail  = 0;
  int beat_g  = 0;
  logic [63:0] exp_q[$];

  vec_stream_row_collector dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .row_valid(row_valid), .row_release(row_release),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_vec(rd_vec), .rd_vec_valid(rd_vec_valid),
    .wr_tile_cnt(wr_tile_cnt), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seq_tile(input int g);
    int a;
    a = 4 * g;
    return {16'(a + 3), 16'(a + 2), 16'(a + 1), 16'(a)};
  endfunction

  function automatic logic [63:0] neg_tile(input int k);
    return {16'(-k), 16'(k), 16'hFFFF, 16'h8000};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // holds the beat until accepted; waits counts cycles spent stalled
  task automatic send(input logic [63:0] v, output bit ok, output int waits);
    bit acc;
    ok = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_vec = v;
    for (int c = 0; c < 200; c++) begin
      acc = in_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    in_valid = 1'b0;
  endtask

  task automatic stream_seq(input int n, output int stalls);
    bit ok;
    int w;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send(seq_tile(beat_g), ok, w);
      stalls += w;
      if (!ok) begin
        chk("accept_timeout", 64'd0, 64'd1);
        return;
      end
      beat_g++;
    end
  endtask

  task automatic rd(input int idx, input logic [63:0] exp, input bit valid);
    rd_en = 1'b1;
    rd_idx = 6'(idx);
    if (valid) exp_q.push_back(exp);
    step();
    rd_en = 1'b0;
    chk("rd_vec_valid", 64'(rd_vec_valid), 64'(valid));
    if (!valid) chk("rd_hold", rd_vec, exp);
  endtask

  task automatic rd_burst(input int first, input int n, input int base_beat);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      rd_idx = 6'(first + i);
      exp_q.push_back(seq_tile(base_beat + first + i));
      step();
      chk("burst_valid", 64'(rd_vec_valid), 64'd1);
    end
    rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_vec_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
      else chk("rd_vec", rd_vec, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    bit ok;
    int w;

    // reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_row_valid", 64'(row_valid), 64'd0);
    chk("rst_rd_vec", rd_vec, 64'd0);
    chk("rst_rows_done", 64'(rows_done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);

    // ignored controls with no row
    row_release = 1'b1;
    rd(3, 64'd0, 1'b0);
    row_release = 1'b0;
    chk("ign_row_valid", 64'(row_valid), 64'd0);
    chk("ign_wr_cnt", 64'(wr_tile_cnt), 64'd0);
    chk("ign_in_ready", 64'(in_ready), 64'd1);

    // single row
    stream_seq(63, stalls);
    chk("row_valid_early", 64'(row_valid), 64'd0);
    stream_seq(1, w);
    stalls += w;
    chk("ready_throughout", 64'(stalls), 64'd0);
    chk("row_valid_after_63", 64'(row_valid), 64'd1);
    chk("rows_done_1", 64'(rows_done), 64'd1);
    rd(5, seq_tile(5), 1'b1);

    // second row fills the other bank, then back-pressure
    stream_seq(63, stalls);
    chk("ready_before_127", 64'(in_ready), 64'd1);
    stream_seq(1, stalls);
    chk("ready_full", 64'(in_ready), 64'd0);
    chk("rows_done_2", 64'(rows_done), 64'd2);
    in_valid = 1'b1;
    in_vec = seq_tile(128);
    repeat (3) step();
    chk("held_wr_cnt", 64'(wr_tile_cnt), 64'd0);
    chk("held_ready", 64'(in_ready), 64'd0);
    rd(0, seq_tile(0), 1'b1);
    row_release = 1'b1;
    step();
    row_release = 1'b0;
    chk("ready_after_release", 64'(in_ready), 64'd1);
    chk("row_valid_row2", 64'(row_valid), 64'd1);
    step();
    in_valid = 1'b0;
    beat_g = 129;
    chk("beat128_accepted", 64'(wr_tile_cnt), 64'd1);
    rd(0, seq_tile(64), 1'b1);

    // release in the same cycle as the row-completing beat
    stream_seq(62, stalls);
    row_release = 1'b1;
    send(seq_tile(191), ok, w);
    row_release = 1'b0;
    beat_g = 192;
    chk("sim_accept", 64'(ok), 64'd1);
    chk("sim_row_valid", 64'(row_valid), 64'd1);
    chk("sim_rows_done", 64'(rows_done), 64'd3);
    chk("sim_in_ready", 64'(in_ready), 64'd1);
    rd(0, seq_tile(128), 1'b1);
    rd_burst(60, 4, 128);

    // asynchronous reset mid-row
    stream_seq(10, stalls);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_row_valid", 64'(row_valid), 64'd0);
    chk("arst_rd_vec_valid", 64'(rd_vec_valid), 64'd0);
    chk("arst_rd_vec", rd_vec, 64'd0);
    chk("arst_rows_done", 64'(rows_done), 64'd0);
    chk("arst_wr_cnt", 64'(wr_tile_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_ready_after", 64'(in_ready), 64'd1);
    beat_g = 1000;
    stream_seq(64, stalls);
    chk("arst_row_valid_after", 64'(row_valid), 64'd1);
    chk("arst_rows_done_after", 64'(rows_done), 64'd1);
    rd(0, seq_tile(1000), 1'b1);
    rd(63, seq_tile(1063), 1'b1);

    // negative data, read and release in the same cycle
    row_release = 1'b1;
    step();
    row_release = 1'b0;
    chk("neg_row_free", 64'(row_valid), 64'd0);
    for (int k = 0; k < 64; k++) begin
      send(neg_tile(k), ok, w);
      if (!ok) chk("neg_accept_timeout", 64'd0, 64'd1);
    end
    chk("neg_row_valid", 64'(row_valid), 64'd1);
    rd_en = 1'b1;
    rd_idx = 6'd63;
    row_release = 1'b1;
    exp_q.push_back(neg_tile(63));
    step();
    rd_en = 1'b0;
    row_release = 1'b0;
    chk("neg_rd_valid", 64'(rd_vec_valid), 64'd1);
    chk("neg_row_valid_after", 64'(row_valid), 64'd0);
    step();
    rd(7, neg_tile(63), 1'b0);

    step();
    step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
